// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bank
//  Purpose  : Single-clock memory with one read/write port (A) and one
//             read-only port (B), optional output register gated by oce,
//             selectable read-first / write-first collision behaviour and
//             a full-memory clear engine.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bank #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 13,
  parameter int                OUT_REG     = 0,
  parameter int                WRITE_FIRST = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cea,
  input  logic              wea,
  input  logic [ADDR_W-1:0] ada,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              douta_vld,
  input  logic              ceb,
  input  logic [ADDR_W-1:0] adb,
  output logic [DATA_W-1:0] doutb,
  output logic              doutb_vld,
  input  logic              oce,
  input  logic              clr_start,
  output logic              busy
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam bit         WF    = (WRITE_FIRST != 0);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              w_busy;
  logic              w_clr_we;

  logic              w_wr_a;
  logic              w_rd_a;
  logic              w_rd_b;
  logic              w_coll;
  logic [DATA_W-1:0] w_b_data;

  logic [DATA_W-1:0] s1a_q;
  logic [DATA_W-1:0] s1b_q;

  // Clear FSM state and pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Clear FSM next state: sweep every address once, then go back to idle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Pointer wraps naturally at ADDR_W bits after the last word
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Clear FSM outputs: busy flag and clear-write strobe
  always_comb begin
    w_busy   = 1'b0;
    w_clr_we = 1'b0;
    if (state_q == ST_CLEAR) begin
      w_busy   = 1'b1;
      w_clr_we = 1'b1;
    end
  end

  assign busy = w_busy;

  // User accesses are locked out for the whole clear sweep
  assign w_wr_a = cea & wea & ~w_busy;
  assign w_rd_a = cea & ~wea & ~w_busy;
  assign w_rd_b = ceb & ~w_busy;

  // Port-B read data, bypassing the incoming A write when write-first
  assign w_coll   = w_wr_a & w_rd_b & (ada == adb);
  assign w_b_data = (WF && w_coll) ? dina : mem[adb];

  // Memory array write: contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem[ptr_q] <= CLEAR_VAL;
    end else if (w_wr_a) begin
      mem[ada] <= dina;
    end
  end

  // Stage-1 read registers: only updated by an accepted read, so they hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1a_q <= '0;
      s1b_q <= '0;
    end else begin
      if (w_rd_a) s1a_q <= mem[ada];
      if (w_rd_b) s1b_q <= w_b_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              pend_a_q;
      logic              pend_b_q;
      logic              ova_q;
      logic              ovb_q;
      logic [DATA_W-1:0] oa_q;
      logic [DATA_W-1:0] ob_q;

      // Output stage: move pending stage-1 data forward only when oce allows
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_a_q <= 1'b0;
          pend_b_q <= 1'b0;
          ova_q    <= 1'b0;
          ovb_q    <= 1'b0;
          oa_q     <= '0;
          ob_q     <= '0;
        end else begin
          // A new read re-arms pending even on the edge that drains it
          pend_a_q <= w_rd_a | (pend_a_q & ~oce);
          pend_b_q <= w_rd_b | (pend_b_q & ~oce);
          ova_q    <= oce & pend_a_q;
          ovb_q    <= oce & pend_b_q;
          if (oce && pend_a_q) oa_q <= s1a_q;
          if (oce && pend_b_q) ob_q <= s1b_q;
        end
      end

      assign douta     = oa_q;
      assign doutb     = ob_q;
      assign douta_vld = ova_q;
      assign doutb_vld = ovb_q;
    end else begin : g_no_reg
      logic va_q;
      logic vb_q;
      logic unused_oce;

      // Valid flags follow the accepted read by exactly one cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          va_q <= 1'b0;
          vb_q <= 1'b0;
        end else begin
          va_q <= w_rd_a;
          vb_q <= w_rd_b;
        end
      end

      assign unused_oce = oce;
      assign douta      = s1a_q;
      assign doutb      = s1b_q;
      assign douta_vld  = va_q;
      assign doutb_vld  = vb_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bank
//  Purpose  : Directed self-checking bench for mem_bank. Three instances:
//             A = defaults (latency 1, read-first), B = output register and
//             write-first, C = 16-word bank with 0xFF clear value.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cea = 1'b0, wea = 1'b0, ceb = 1'b0, oce = 1'b1, clr_c = 1'b0;
  logic        clr_off = 1'b0;
  logic [12:0] ada = '0, adb = '0;
  logic [7:0]  dina = '0;

  logic [7:0]  douta_a, doutb_a, douta_b, doutb_b, douta_c, doutb_c;
  logic        dav_a, dbv_a, busy_a, dav_b, dbv_b, busy_b, dav_c, dbv_c, busy_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bank #(.DATA_W(8), .ADDR_W(13), .OUT_REG(0), .WRITE_FIRST(0), .CLEAR_VAL(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n), .cea(cea), .wea(wea), .ada(ada), .dina(dina),
    .douta(douta_a), .douta_vld(dav_a), .ceb(ceb), .adb(adb), .doutb(doutb_a),
    .doutb_vld(dbv_a), .oce(oce), .clr_start(clr_off), .busy(busy_a));

  mem_bank #(.DATA_W(8), .ADDR_W(6), .OUT_REG(1), .WRITE_FIRST(1), .CLEAR_VAL(8'h00)) u_b (
    .clk(clk), .rst_n(rst_n), .cea(cea), .wea(wea), .ada(ada[5:0]), .dina(dina),
    .douta(douta_b), .douta_vld(dav_b), .ceb(ceb), .adb(adb[5:0]), .doutb(doutb_b),
    .doutb_vld(dbv_b), .oce(oce), .clr_start(clr_off), .busy(busy_b));

  mem_bank #(.DATA_W(8), .ADDR_W(4), .OUT_REG(0), .WRITE_FIRST(0), .CLEAR_VAL(8'hFF)) u_c (
    .clk(clk), .rst_n(rst_n), .cea(cea), .wea(wea), .ada(ada[3:0]), .dina(dina),
    .douta(douta_c), .douta_vld(dav_c), .ceb(ceb), .adb(adb[3:0]), .doutb(doutb_c),
    .doutb_vld(dbv_c), .oce(oce), .clr_start(clr_c), .busy(busy_c));

  typedef struct {
    logic        cea;
    logic        wea;
    logic [12:0] ada;
    logic [7:0]  dina;
    logic        ceb;
    logic [12:0] adb;
    logic        ea_v;
    logic [7:0]  ea;
    logic        eb_v;
    logic [7:0]  eb;
  } vec_t;

  vec_t tbl [12];

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic idle();
    cea = 1'b0; wea = 1'b0; ceb = 1'b0; clr_c = 1'b0;
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] d);
    cea = 1'b1; wea = 1'b1; ada = a; dina = d;
    @(negedge clk);
    idle();
  endtask

  // Port-A read on the 16-word instance, checked one cycle later
  task automatic rd_c(input logic [12:0] a, input logic [7:0] exp, input string nm);
    cea = 1'b1; wea = 1'b0; ada = a;
    @(negedge clk);
    idle();
    chk8(nm, douta_c, exp);
    chk1({nm, "_vld"}, dav_c, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int vld_seen;

    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk8("rst douta_a", douta_a, 8'h00);
    chk8("rst doutb_a", doutb_a, 8'h00);
    chk1("rst dav_a", dav_a, 1'b0);
    chk1("rst dbv_a", dbv_a, 1'b0);
    chk1("rst busy_c", busy_c, 1'b0);
    chk1("rst dbv_b", dbv_b, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- table vectors on instance A ----------------
    //            cea   wea   ada       dina   ceb   adb      | ea_v  ea     eb_v  eb
    tbl[0]  = '{1'b1, 1'b1, 13'h0010, 8'hA5, 1'b0, 13'h0000, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 13'h0010, 8'h00, 1'b0, 13'h0000, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 13'h0000, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 13'h0020, 8'h11, 1'b0, 13'h0000, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 13'h0020, 8'h22, 1'b1, 13'h0020, 1'b0, 8'hA5, 1'b1, 8'h11};
    tbl[5]  = '{1'b1, 1'b0, 13'h0010, 8'h00, 1'b1, 13'h0020, 1'b1, 8'hA5, 1'b1, 8'h22};
    tbl[6]  = '{1'b1, 1'b1, 13'h1FFF, 8'h5A, 1'b0, 13'h0000, 1'b0, 8'hA5, 1'b0, 8'h22};
    tbl[7]  = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b1, 13'h0010, 1'b1, 8'h5A, 1'b1, 8'hA5};
    tbl[8]  = '{1'b1, 1'b1, 13'h0005, 8'h3C, 1'b0, 13'h0000, 1'b0, 8'h5A, 1'b0, 8'hA5};
    tbl[9]  = '{1'b0, 1'b1, 13'h0005, 8'hEE, 1'b1, 13'h0005, 1'b0, 8'h5A, 1'b1, 8'h3C};
    tbl[10] = '{1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 13'h0000, 1'b0, 8'h5A, 1'b0, 8'h3C};
    tbl[11] = '{1'b1, 1'b0, 13'h0005, 8'h00, 1'b0, 13'h0000, 1'b1, 8'h3C, 1'b0, 8'h3C};

    oce = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cea = tbl[i].cea; wea = tbl[i].wea; ada = tbl[i].ada; dina = tbl[i].dina;
      ceb = tbl[i].ceb; adb = tbl[i].adb;
      @(negedge clk);
      chk1($sformatf("v%0d douta_vld", i), dav_a, tbl[i].ea_v);
      chk8($sformatf("v%0d douta", i), douta_a, tbl[i].ea);
      chk1($sformatf("v%0d doutb_vld", i), dbv_a, tbl[i].eb_v);
      chk8($sformatf("v%0d doutb", i), doutb_a, tbl[i].eb);
    end
    idle();
    @(negedge clk);

    // ---------------- collision: read-first (A) vs write-first (B) ----------------
    wr(13'h0020, 8'h11);
    cea = 1'b1; wea = 1'b1; ada = 13'h0020; dina = 8'h22; ceb = 1'b1; adb = 13'h0020;
    @(negedge clk);
    idle();
    chk8("coll rf doutb", doutb_a, 8'h11);
    chk1("coll rf vld", dbv_a, 1'b1);
    chk1("coll wf vld early", dbv_b, 1'b0);
    @(negedge clk);
    chk8("coll wf doutb", doutb_b, 8'h22);
    chk1("coll wf vld", dbv_b, 1'b1);
    @(negedge clk);
    chk1("coll wf vld drop", dbv_b, 1'b0);

    // ---------------- output register held off by oce ----------------
    oce = 1'b0; ceb = 1'b1; adb = 13'h0005;
    @(negedge clk);
    idle();
    chk1("oce read vld", dbv_b, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("oce hold%0d vld", k), dbv_b, 1'b0);
      chk8($sformatf("oce hold%0d doutb", k), doutb_b, 8'h22);
    end
    oce = 1'b1;
    @(negedge clk);
    chk8("oce doutb", doutb_b, 8'h3C);
    chk1("oce vld", dbv_b, 1'b1);
    @(negedge clk);
    chk1("oce one pulse", dbv_b, 1'b0);
    chk8("oce hold doutb", doutb_b, 8'h3C);

    // Pending value overwritten by a newer read before oce arrives
    oce = 1'b0; ceb = 1'b1; adb = 13'h0010;
    @(negedge clk);
    adb = 13'h0020;
    @(negedge clk);
    idle();
    chk1("ovr vld early", dbv_b, 1'b0);
    oce = 1'b1;
    @(negedge clk);
    chk8("ovr doutb", doutb_b, 8'h22);
    chk1("ovr vld", dbv_b, 1'b1);
    @(negedge clk);
    chk1("ovr one pulse", dbv_b, 1'b0);

    // Port A latency two on the registered instance
    cea = 1'b1; wea = 1'b0; ada = 13'h003F;
    @(negedge clk);
    idle();
    chk1("lat2 a early", dav_b, 1'b0);
    @(negedge clk);
    chk1("lat2 a vld", dav_b, 1'b1);
    chk8("lat2 a douta", douta_b, 8'h5A);

    // ---------------- clear engine on 16-word instance ----------------
    for (int i = 0; i < 16; i++) wr(13'(i), 8'h40 + 8'(i));
    clr_c = 1'b1; cea = 1'b1; wea = 1'b0; ada = 13'h0002;
    @(negedge clk);
    idle();
    chk1("clr busy first", busy_c, 1'b1);
    chk1("clr coincident vld", dav_c, 1'b1);
    chk8("clr coincident douta", douta_c, 8'h42);
    busy_cycles = 0;
    vld_seen    = 0;
    for (int k = 0; k < 40 && busy_c; k++) begin
      busy_cycles++;
      cea = 1'b1; wea = 1'b1; ada = 13'h0007; dina = 8'h00;
      ceb = 1'b1; adb = 13'h0003; clr_c = (k == 4);
      @(negedge clk);
      if (dav_c || dbv_c) vld_seen++;
    end
    idle();
    n_tests++;
    if (busy_cycles != 16) begin
      n_fail++;
      $display("FAIL clr busy length: got %0d cycles expected 16", busy_cycles);
    end
    n_tests++;
    if (vld_seen != 0) begin
      n_fail++;
      $display("FAIL clr vld while busy: got %0d pulses expected 0", vld_seen);
    end
    for (int i = 0; i < 16; i++) rd_c(13'(i), 8'hFF, $sformatf("clr word%0d", i));

    // ---------------- reset in the middle of a clear ----------------
    for (int i = 0; i < 16; i++) wr(13'(i), 8'h50 + 8'(i));
    clr_c = 1'b1;
    @(negedge clk);
    clr_c = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk8("mid rst douta", douta_c, 8'h00);
    chk8("mid rst doutb", doutb_c, 8'h00);
    chk1("mid rst douta_vld", dav_c, 1'b0);
    chk1("mid rst busy", busy_c, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post rst busy", busy_c, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i < 5)       rd_c(13'(i), 8'hFF, $sformatf("abort word%0d", i));
      else if (i > 5)  rd_c(13'(i), 8'h50 + 8'(i), $sformatf("abort word%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (1..32).
REQ-002 SHALL have parameter ADDR_W, default 13, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter OUT_REG, default 0; 0 = read latency 1, 1 = read latency 2 via output register gated by oce.
REQ-004 SHALL have parameter WRITE_FIRST, default 0; 0 = read-first, 1 = write-first on port-A/port-B address collision.
REQ-005 SHALL have parameter CLEAR_VAL, default 0, DATA_W-bit fill value for the clear engine.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port cea, input, 1, port-A enable.
REQ-009 SHALL have port wea, input, 1, port-A write when cea=1; read when 0.
REQ-010 SHALL have port ada, input, ADDR_W, port-A address.
REQ-011 SHALL have port dina, input, DATA_W, port-A write data.
REQ-012 SHALL have port douta, output, DATA_W, port-A read data.
REQ-013 SHALL have port douta_vld, output, 1, douta holds new read data this cycle.
REQ-014 SHALL have port ceb, input, 1, port-B (read-only) enable.
REQ-015 SHALL have port adb, input, ADDR_W, port-B address.
REQ-016 SHALL have port doutb, output, DATA_W, port-B read data.
REQ-017 SHALL have port doutb_vld, output, 1, doutb holds new read data this cycle.
REQ-018 SHALL have port oce, input, 1, output-register enable; ignored when OUT_REG=0.
REQ-019 SHALL have port clr_start, input, 1, one-cycle pulse starting a full-memory clear.
REQ-020 SHALL have port busy, output, 1, clear engine active.

Function
REQ-021 SHALL write dina to mem[ada] on the edge where cea=1, wea=1, busy=0.
REQ-022 SHALL, with OUT_REG=0, present mem[addr] on douta/doutb and pulse the matching _vld one cycle after a read enable (cea&~wea, or ceb) with busy=0.
REQ-023 SHALL, with OUT_REG=1, capture stage-1 data into the output register only on edges with oce=1; _vld pulses for one cycle when a pending stage-1 value is transferred; a pending value is held until oce=1 and overwritten by a newer read.
REQ-024 SHALL hold douta/doutb between reads; writes never alter douta.
REQ-025 SHALL, on the same edge port-A writes address X and port-B reads X, return old mem[X] on doutb when WRITE_FIRST=0 and dina when WRITE_FIRST=1.
REQ-026 SHALL implement clear FSM states IDLE and CLEAR; IDLE->CLEAR on clr_start=1, clear pointer loaded with 0, busy=1 from the next cycle.
REQ-027 SHALL, in CLEAR, write CLEAR_VAL to mem[ptr] each cycle and increment ptr; after writing address 2**ADDR_W-1 return to IDLE, busy=0 the following cycle; total busy = 2**ADDR_W cycles.
REQ-028 SHALL ignore cea, ceb and clr_start while busy=1; no user write, no _vld pulse.
REQ-029 SHALL wrap ptr at ADDR_W bits; no address beyond depth is touched.
REQ-030 SHALL ignore clr_start coincident with a user access in IDLE for that edge's access only: the access completes, the clear starts.

Reset
REQ-031 SHALL on rst_n=0 immediately force douta=0, doutb=0, douta_vld=0, doutb_vld=0, busy=0, FSM=IDLE, ptr=0, pending output flags cleared.
REQ-032 SHALL not initialise memory contents on reset; reset during CLEAR aborts it, leaving already-cleared words cleared and the rest unchanged.

Verification
REQ-033 SHALL test OUT_REG=0: write 0xA5 to 0x0010, read A at 0x0010 next cycle -> douta=0xA5, douta_vld=1 exactly one cycle later.
REQ-034 SHALL test collision: mem[0x20]=0x11, A writes 0x22 to 0x20 while B reads 0x20 -> doutb=0x11 (WRITE_FIRST=0), 0x22 (WRITE_FIRST=1).
REQ-035 SHALL test OUT_REG=1: B reads 0x05 (value 0x3C) with oce=0 for 3 cycles then 1 -> doutb_vld=0 until the oce edge, then doutb=0x3C, one vld pulse.
REQ-036 SHALL test clear with ADDR_W=4, CLEAR_VAL=0xFF: pulse clr_start -> busy high 16 cycles, cea writes during busy ignored, all 16 words read 0xFF afterwards.
REQ-037 SHALL test reset mid-clear: rst_n low at ptr=5 -> outputs 0 asynchronously, busy=0, words 0..4 = CLEAR_VAL, words 6..15 retain prior data.
